// File: rtl/rns_crt_reconstruct_pkg.sv
// rns_crt_reconstruct_pkg
//   Shared CRT parameters for the inverse-RNS stage: default residue width,
//   number of moduli, the modulus table (same values as the decomposition
//   stage) and the controller state encodings.
//   The derived constants (Q, M[i], inv[i], Barrett factors) are computed
//   from the modulus table at elaboration time inside rns_crt_reconstruct,
//   so a different modulus set only needs a new CRT_MODULI value.
//   No ports (package).
package rns_crt_reconstruct_pkg;

    localparam int CRT_SWIDTH = 32;
    localparam int CRT_PARTS  = 4;
    localparam int CRT_LWIDTH = CRT_SWIDTH * CRT_PARTS;
    localparam int CRT_IDXW   = 2;

    // q[0] sits in the least significant SWIDTH bits.
    localparam logic [CRT_PARTS*CRT_SWIDTH-1:0] CRT_MODULI = {
        32'd4294967197,
        32'd4294967231,
        32'd4294967279,
        32'd4294967291
    };

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] TERM    = 2'd1;
    localparam logic [1:0] ACC     = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

endpackage

// File: rtl/rns_crt_reconstruct_mod_mult_reduce.sv
// mod_mult_reduce
//   Combinational (a*b) mod q using Barrett reduction.
//   Ports:
//     a, b : SWIDTH-bit operands, any value below 2^SWIDTH (need not be < q)
//     q    : SWIDTH-bit modulus, q >= 2
//     mu   : 2*SWIDTH-bit Barrett factor floor(2^(2*SWIDTH) / q)
//     r    : SWIDTH-bit result, always < q
//   With p < 2^(2*SWIDTH) the quotient estimate is at most one below the
//   true quotient, so the remainder is below 2q and one subtract finishes.
module mod_mult_reduce
    import rns_crt_reconstruct_pkg::*;
#(
    parameter int SWIDTH = CRT_SWIDTH
) (
    input  logic [SWIDTH-1:0]   a,
    input  logic [SWIDTH-1:0]   b,
    input  logic [SWIDTH-1:0]   q,
    input  logic [2*SWIDTH-1:0] mu,
    output logic [SWIDTH-1:0]   r
);

    localparam int PW = 2 * SWIDTH;

    logic [PW-1:0]   prod;
    logic [2*PW-1:0] est;
    logic [PW-1:0]   qhat;
    logic [PW-1:0]   q_ext;
    logic [PW-1:0]   rem;

    always_comb begin
        q_ext = {{SWIDTH{1'b0}}, q};
        prod  = {{SWIDTH{1'b0}}, a} * {{SWIDTH{1'b0}}, b};
        est   = {{PW{1'b0}}, prod} * {{PW{1'b0}}, mu};
        qhat  = PW'(est >> PW);
        // qhat*q never exceeds prod, so the low PW bits are exact.
        rem   = prod - q_ext * qhat;
        r     = (rem >= q_ext) ? SWIDTH'(rem - q_ext) : SWIDTH'(rem);
    end

endmodule

// File: rtl/rns_crt_reconstruct.sv
// rns_crt_reconstruct
//   Inverse-RNS stage. Accepts PARTS residues serially (q[0] first) and
//   rebuilds x mod Q by the CRT: acc += ((r_i * inv_i) mod q_i) * M_i mod Q.
//   Each residue takes three cycles (COLLECT -> TERM -> ACC); the result is
//   held in DONE until the consumer takes it.
//   Ports:
//     clk, reset            : rising-edge clock, synchronous active-high reset
//     in_valid/in_ready     : residue handshake, in_data = r_i, in_last marks
//                             the source's idea of the final residue
//     out_valid/out_ready   : result handshake, out_data = x (< Q)
//     frame_err             : with out_valid, in_last was misplaced
module rns_crt_reconstruct
    import rns_crt_reconstruct_pkg::*;
#(
    parameter int SWIDTH = CRT_SWIDTH,
    parameter int PARTS  = CRT_PARTS,
    parameter int LWIDTH = SWIDTH * PARTS,
    parameter int IDXW   = CRT_IDXW,
    parameter logic [PARTS*SWIDTH-1:0] MODULI = CRT_MODULI
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SWIDTH-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LWIDTH-1:0] out_data,
    output logic              frame_err
);

    localparam int PW  = 2 * SWIDTH;
    localparam int PW1 = PW + 1;
    localparam int EW  = PW + 2;

    typedef logic [PARTS-1:0][SWIDTH-1:0] stab_t;
    typedef logic [PARTS-1:0][PW-1:0]     wtab_t;
    typedef logic [PARTS-1:0][LWIDTH-1:0] ltab_t;

    localparam stab_t Q_TAB = MODULI;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PARTS - 1);

    // Elaboration-time constant tables derived from the modulus set.
    function automatic logic [LWIDTH-1:0] calc_q();
        logic [LWIDTH-1:0] p;
        p = LWIDTH'(1);
        for (int i = 0; i < PARTS; i++)
            p = p * LWIDTH'(Q_TAB[i]);
        return p;
    endfunction

    function automatic ltab_t calc_m(input logic [LWIDTH-1:0] qall);
        ltab_t m;
        for (int i = 0; i < PARTS; i++)
            m[i] = qall / LWIDTH'(Q_TAB[i]);
        return m;
    endfunction

    // Extended Euclid; moduli are pairwise coprime so the inverse exists.
    function automatic logic [SWIDTH-1:0] inv_mod(input logic [SWIDTH-1:0] a,
                                                  input logic [SWIDTH-1:0] m);
        logic signed [EW-1:0] t, t_n, r, r_n, quo, tmp;
        t   = '0;
        t_n = EW'(1);
        r   = EW'(m);
        r_n = EW'(a);
        while (r_n != '0) begin
            quo = r / r_n;
            tmp = t - quo * t_n;
            t   = t_n;
            t_n = tmp;
            tmp = r - quo * r_n;
            r   = r_n;
            r_n = tmp;
        end
        if (t[EW-1])
            t = t + EW'(m);
        return SWIDTH'(t);
    endfunction

    function automatic stab_t calc_inv(input ltab_t m);
        stab_t v;
        for (int i = 0; i < PARTS; i++)
            v[i] = inv_mod(SWIDTH'(m[i] % LWIDTH'(Q_TAB[i])), Q_TAB[i]);
        return v;
    endfunction

    function automatic wtab_t calc_mu();
        wtab_t v;
        logic [PW:0] num;
        num     = '0;
        num[PW] = 1'b1;
        for (int i = 0; i < PARTS; i++)
            v[i] = PW'(num / PW1'(Q_TAB[i]));
        return v;
    endfunction

    localparam logic [LWIDTH-1:0] Q_MOD = calc_q();
    localparam ltab_t M_TAB   = calc_m(Q_MOD);
    localparam stab_t INV_TAB = calc_inv(M_TAB);
    localparam wtab_t MU_TAB  = calc_mu();

    logic [1:0]        state;
    logic [IDXW-1:0]   idx;
    logic [SWIDTH-1:0] r_reg;
    logic [SWIDTH-1:0] y;
    logic [SWIDTH-1:0] y_next;
    logic [LWIDTH-1:0] acc;
    logic [LWIDTH-1:0] acc_next;
    logic [LWIDTH:0]   term;
    logic [LWIDTH:0]   sum;
    logic              err;

    // TERM stage: y = (r_i * inv_i) mod q_i
    mod_mult_reduce #(
        .SWIDTH (SWIDTH)
    ) u_term (
        .a  (r_reg),
        .b  (INV_TAB[idx]),
        .q  (Q_TAB[idx]),
        .mu (MU_TAB[idx]),
        .r  (y_next)
    );

    // ACC stage: y < q_i so y*M_i < Q, and acc < Q keeps sum below 2Q.
    always_comb begin
        term     = {{(LWIDTH + 1 - SWIDTH){1'b0}}, y} * {1'b0, M_TAB[idx]};
        sum      = {1'b0, acc} + term;
        acc_next = (sum >= {1'b0, Q_MOD}) ? LWIDTH'(sum - {1'b0, Q_MOD})
                                          : LWIDTH'(sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            idx       <= '0;
            r_reg     <= '0;
            y         <= '0;
            acc       <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid && in_ready) begin
                        r_reg    <= in_data;
                        err      <= err | (in_last != (idx == LAST_IDX));
                        in_ready <= 1'b0;
                        state    <= TERM;
                    end else begin
                        // Covers the first cycle out of reset.
                        in_ready <= 1'b1;
                    end
                end
                TERM: begin
                    y     <= y_next;
                    state <= ACC;
                end
                ACC: begin
                    acc <= acc_next;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx      <= idx + IDXW'(1);
                        in_ready <= 1'b1;
                        state    <= COLLECT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        err       <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    assign out_data  = acc;
    assign frame_err = err;

endmodule

// File: tb/tb_rns_crt_reconstruct.sv
// tb_rns_crt_reconstruct
//   Bench for rns_crt_reconstruct with q = {3,5,7}, Q = 105.
//   The reference finds the unique x < Q matching every residue by search.
//   No ports.
module tb_rns_crt_reconstruct;

    localparam int SW = 4;
    localparam int NP = 3;
    localparam int LW = 12;
    localparam int QM [NP] = '{3, 5, 7};
    localparam int QPROD = 105;

    typedef int frame_t [NP];

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_data;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rns_crt_reconstruct #(
        .SWIDTH (SW),
        .PARTS  (NP),
        .LWIDTH (LW),
        .IDXW   (2),
        .MODULI ({4'd7, 4'd5, 4'd3})
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err)
    );

    // Unique x < Q with x = r_j mod q_j for j <= upto and x = 0 mod q_j beyond.
    function automatic int ref_crt(input frame_t rs, input int upto);
        for (int x = 0; x < QPROD; x++) begin
            bit match = 1'b1;
            for (int j = 0; j < NP; j++) begin
                int want = (j <= upto) ? (rs[j] % QM[j]) : 0;
                if ((x % QM[j]) != want) match = 1'b0;
            end
            if (match) return x;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [SW-1:0] d, input logic last, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            else step();
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = SW'($urandom);
    endtask

    // Sends one frame; returns at the cycle the last accumulate is visible.
    task automatic drive_frame(input frame_t rs, input int last_pos, input bit gaps,
                               output frame_t accs, output bit lat_ok, output bit ok);
        bit pok;
        ok     = 1'b1;
        lat_ok = 1'b1;
        for (int i = 0; i < NP; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_data = SW'($urandom);
                    step();
                end
            end
            put(SW'(rs[i]), (i == last_pos), pok);
            if (!pok) ok = 1'b0;
            if (in_ready) lat_ok = 1'b0;
            step();
            if (in_ready || out_valid) lat_ok = 1'b0;
            step();
            if (i == NP - 1 && !out_valid) lat_ok = 1'b0;
            if (i <  NP - 1 && !in_ready) lat_ok = 1'b0;
            accs[i] = int'(dut.acc);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_data=%0d frame_err=%b, required all 0",
                     in_ready, out_valid, out_data, frame_err);
        end
        reset = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        frame_t rs = '{1, 2, 3};
        frame_t accs;
        bit lat_ok, ok;
        out_ready = 1'b1;
        drive_frame(rs, NP - 1, 1'b0, accs, lat_ok, ok);
        checks++;
        if (!(ok && lat_ok)) begin
            errors++;
            $display("FAIL basic_timing: accept=%b latency=%b required 1 1", ok, lat_ok);
        end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (accs[i] !== ref_crt(rs, i)) begin
                errors++;
                $display("FAIL basic_acc%0d: got %0d required %0d", i, accs[i], ref_crt(rs, i));
            end
        end
        checks++;
        if (out_data !== LW'(52) || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %0d err=%b required 52 err=0", out_data, frame_err);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut.acc !== '0) begin
            errors++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b acc=%0d required 0 1 0",
                     out_valid, in_ready, dut.acc);
        end
    endtask

    task automatic test_subtract();
        frame_t rs = '{2, 4, 6};
        frame_t accs;
        bit lat_ok, ok;
        out_ready = 1'b1;
        drive_frame(rs, NP - 1, 1'b0, accs, lat_ok, ok);
        checks++;
        if (accs[1] !== 14 || accs[0] !== ref_crt(rs, 0)) begin
            errors++;
            $display("FAIL subtract_acc: got %0d,%0d required %0d,14", accs[0], accs[1], ref_crt(rs, 0));
        end
        checks++;
        if (out_data !== LW'(ref_crt(rs, NP - 1)) || frame_err !== 1'b0 || !ok || !lat_ok) begin
            errors++;
            $display("FAIL subtract_result: got %0d err=%b required %0d err=0",
                     out_data, frame_err, ref_crt(rs, NP - 1));
        end
        step();
    endtask

    task automatic test_back_to_back();
        frame_t rs0 = '{0, 0, 0};
        frame_t rs1 = '{1, 0, 0};
        frame_t accs;
        bit lat_ok, ok;
        out_ready = 1'b1;
        drive_frame(rs0, NP - 1, 1'b0, accs, lat_ok, ok);
        checks++;
        if (out_data !== '0 || !out_valid || !ok || !lat_ok) begin
            errors++;
            $display("FAIL b2b_zero: got %0d valid=%b required 0 valid=1", out_data, out_valid);
        end
        drive_frame(rs1, NP - 1, 1'b0, accs, lat_ok, ok);
        checks++;
        if (accs[0] !== 70 || out_data !== LW'(ref_crt(rs1, NP - 1)) || !ok || !lat_ok) begin
            errors++;
            $display("FAIL b2b_second: acc0=%0d out=%0d required 70 %0d",
                     accs[0], out_data, ref_crt(rs1, NP - 1));
        end
        step();
    endtask

    task automatic test_hold();
        frame_t rs = '{1, 2, 3};
        frame_t accs;
        bit lat_ok, ok;
        out_ready = 1'b0;
        drive_frame(rs, NP - 1, 1'b0, accs, lat_ok, ok);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== LW'(52) || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b data=%0d in_ready=%b required 1 52 0",
                         k, out_valid, out_data, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_last_misplaced();
        frame_t rs = '{1, 2, 3};
        frame_t accs;
        bit lat_ok, ok;
        out_ready = 1'b1;
        drive_frame(rs, 1, 1'b0, accs, lat_ok, ok);
        checks++;
        if (out_data !== LW'(52) || frame_err !== 1'b1 || !lat_ok) begin
            errors++;
            $display("FAIL last_early: got %0d err=%b required 52 err=1", out_data, frame_err);
        end
        step();
        drive_frame(rs, NP - 1, 1'b0, accs, lat_ok, ok);
        checks++;
        if (out_data !== LW'(52) || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL last_clean_after: got %0d err=%b required 52 err=0", out_data, frame_err);
        end
        step();
    endtask

    task automatic test_reset_mid();
        frame_t rs = '{2, 4, 6};
        frame_t accs;
        bit lat_ok, ok, pok;
        out_ready = 1'b1;
        put(SW'(1), 1'b0, pok);
        step();
        step();
        put(SW'(2), 1'b0, pok);
        reset = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: in_ready=%b out_valid=%b out_data=%0d frame_err=%b, required all 0",
                     in_ready, out_valid, out_data, frame_err);
        end
        reset = 1'b0;
        step();
        drive_frame(rs, NP - 1, 1'b0, accs, lat_ok, ok);
        checks++;
        if (accs[0] !== ref_crt(rs, 0) || out_data !== LW'(104) || frame_err !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL midreset_frame: acc0=%0d out=%0d err=%b required %0d 104 0",
                     accs[0], out_data, frame_err, ref_crt(rs, 0));
        end
        step();
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            frame_t rs;
            frame_t accs;
            bit lat_ok, ok;
            int sel, last_pos, exp;
            bit exp_err;
            for (int j = 0; j < NP; j++) rs[j] = int'($urandom_range(0, 15));
            sel      = int'($urandom_range(0, 5));
            last_pos = (sel == 0) ? -1 : (sel == 1) ? 0 : (sel == 2) ? 1 : NP - 1;
            exp_err  = (last_pos != NP - 1);
            exp      = ref_crt(rs, NP - 1);
            out_ready = 1'(($urandom_range(0, 1)));
            drive_frame(rs, last_pos, 1'b1, accs, lat_ok, ok);
            for (int i = 0; i < NP; i++) begin
                checks++;
                if (accs[i] !== ref_crt(rs, i)) begin
                    errors++;
                    $display("FAIL rand%0d_acc%0d: got %0d required %0d (r=%0d,%0d,%0d)",
                             f, i, accs[i], ref_crt(rs, i), rs[0], rs[1], rs[2]);
                end
            end
            checks++;
            if (out_data !== LW'(exp) || frame_err !== exp_err || !ok || !lat_ok) begin
                errors++;
                $display("FAIL rand%0d_result: got %0d err=%b required %0d err=%b (r=%0d,%0d,%0d)",
                         f, out_data, frame_err, exp, exp_err, rs[0], rs[1], rs[2]);
            end
            if (!out_ready) begin
                repeat ($urandom_range(1, 3)) begin
                    step();
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== LW'(exp)) begin
                        errors++;
                        $display("FAIL rand%0d_hold: valid=%b data=%0d required 1 %0d",
                                 f, out_valid, out_data, exp);
                    end
                end
                out_ready = 1'b1;
            end
            step();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_release: out_valid=%b in_ready=%b required 0 1",
                         f, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_subtract();
        test_back_to_back();
        test_hold();
        test_last_misplaced();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rns_crt_reconstruct.md
Name: rns_crt_reconstruct

Overview:
- Inverse-RNS stage; sits directly downstream of the RNS decomposition block.
- Consumes one frame of PARTS residues, presented serially in modulus order q[0]..q[PARTS-1], and rebuilds the LWIDTH-bit integer x mod Q via the CRT: x = sum_i ((r_i * inv_i) mod q_i) * M_i mod Q, where M_i = Q/q_i and inv_i = M_i^-1 mod q_i.
- Result goes out on a valid/ready port for round-trip checks and for post-homomorphic-evaluation decode.

Parameters:
- SWIDTH, 32, residue/modulus width in bits.
- PARTS, 4, number of RNS moduli per frame.
- LWIDTH, SWIDTH*PARTS, width of the reconstructed integer and of Q.
- IDXW, 2, width of the residue index counter; must satisfy 2^IDXW >= PARTS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  residue present on in_data.
- in_ready  output  1  block can accept a residue this cycle.
- in_data  input  SWIDTH  residue r_i for the current index.
- in_last  input  1  asserted by the source with the final residue of a frame.
- out_valid  output  1  out_data holds a completed reconstruction.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  LWIDTH  reconstructed x, always < Q.
- frame_err  output  1  qualified by out_valid; in_last was misplaced within the frame.

Behaviour:
- Reset: in_ready=0, out_valid=0, out_data=0, frame_err=0, acc=0, idx=0, state=COLLECT. in_ready rises in the first cycle after reset deasserts.
- A transfer occurs on in_valid & in_ready, and likewise on out_valid & out_ready. The upstream stage must hold in_data stable while in_valid=1 and in_ready=0.
- COLLECT: in_ready=1. On a transfer, latch in_data into r_reg and latch the error term err |= (in_last != (idx==PARTS-1)); go to TERM.
- TERM: in_ready=0. Compute y <= (r_reg * inv[idx]) mod q[idx]. The product is 2*SWIDTH wide. The reduction must be exact for any r_reg < 2^SWIDTH, so residues >= q_i are still handled correctly. Go to ACC.
- ACC: in_ready=0.
  - Compute s = acc + y*M[idx] in LWIDTH+1 bits; acc <= (s >= Q) ? s-Q : s. Because acc < Q and y*M_i < Q, one conditional subtract always suffices.
  - If idx==PARTS-1: idx <= 0, go to DONE. Otherwise idx <= idx+1, go to COLLECT.
- DONE:
  - out_valid=1. out_data = acc and frame_err = err, both held stable until out_ready.
  - On the output transfer: out_valid <= 0, acc <= 0, err <= 0, go to COLLECT.
  - in_ready=0 throughout DONE, so the next frame waits.
- Latency:
  - Residue accepted in cycle c gives TERM in c+1 and ACC in c+2.
  - Next in_ready, or out_valid for the last residue, occurs in c+3.
  - Minimum frame period with out_ready tied high is 3*PARTS+1 cycles.
- Frame boundary: the frame length is always PARTS residues, counted by idx. in_last is only checked, never used to terminate early.
- Reset mid-frame or in DONE aborts the frame: partial acc discarded, pending output dropped, all registers return to reset values.
- out_ready held high in DONE: output is consumed in the first DONE cycle.
- Constant tables q, inv, M and Q are synthesis-time constants indexed by idx. They are not loaded at runtime.

Decomposition:
- Shared include/package crt_pars:
  - SWIDTH, PARTS, LWIDTH.
  - Moduli q[i], identical to the decomposition stage's modulus table.
  - inv[i], M[i] and Q, generated by the same script that emits the modulus values.
  - State encodings COLLECT=0, TERM=1, ACC=2, DONE=3.
- One sub-module: mod_mult_reduce (combinational). Takes SWIDTH x SWIDTH operands and modulus q, returns (a*b) mod q, Barrett-based with the same convention as the existing reduction unit. Instantiated once in TERM.
- The LWIDTH-wide multiply-accumulate stays in the top module.

Test Plan:
Test config: SWIDTH=4, PARTS=3, LWIDTH=12, q={3,5,7}, Q=105, M={35,21,15}, inv={2,1,1}.
- Residues 1,2,3 (in_last on 3rd), out_ready=1 -> out_valid in cycle c+3 after 3rd accept, out_data=52, frame_err=0; intermediate acc values 70, 7, 52.
- Residues 2,4,6 -> out_data=104; conditional subtract exercised (119->14); frame_err=0.
- Residues 0,0,0 -> out_data=0. Then a back-to-back frame 1,0,0 -> out_data=70, with acc confirmed cleared between frames.
- Frame 1,2,3 with out_ready=0 for 5 cycles -> out_valid and out_data=52 held stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready rises.
- in_last asserted on 2nd residue of frame 1,2,3 -> out_data=52, frame_err=1. Next clean frame -> frame_err=0.
- reset pulsed in the TERM state of the 2nd residue, then frame 2,4,6 -> out_data=104 (no residue carried over); all outputs 0 in the cycle after reset.
